// File: rtl/mem_clear_sched_if.sv
// mem_clear_sched_if: write-strobe/address bundle between the clear scheduler and the SDRAM/DDR3 controllers
// master: sdr_we, sdr_addr, ddr_we, ddr_addr out; sdr_ack, ddr_busy in
// slave:  mirror of master
interface mem_clear_sched_if #(
  parameter int SDR_AW = 25,
  parameter int DDR_AW = 29
);
  logic              sdr_we;
  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_ack;
  logic              ddr_we;
  logic [DDR_AW-1:0] ddr_addr;
  logic              ddr_busy;
  modport master (output sdr_we, sdr_addr, ddr_we, ddr_addr, input sdr_ack, ddr_busy);
  modport slave  (input sdr_we, sdr_addr, ddr_we, ddr_addr, output sdr_ack, ddr_busy);
endinterface

// File: rtl/mem_clear_sched.sv
// mem_clear_sched: sweeps every SDRAM and DDR3 word address with fill writes and reports completion
// clk_sys, reset_n    : clock, asynchronous active-low reset
// start, hold         : (re)start pulse from IDLE/DONE; level that blocks new writes
// mem (master)        : sdr_we/sdr_addr/sdr_ack req-ack channel, ddr_we/ddr_addr/ddr_busy Avalon channel
// sdr_done, ddr_done  : per-target sweep complete; busy: sweep in progress
// progress            : present only with MEM_CLEAR_PROGRESS_EN, top 8 SDRAM address bits, FF when done
module mem_clear_sched #(
  parameter int SDR_AW     = 25,
  parameter int DDR_AW     = 29,
  parameter bit AUTO_START = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             start,
  input  logic             hold,
  mem_clear_sched_if.master mem,
  output logic             sdr_done,
  output logic             ddr_done,
  output logic             busy
`ifdef MEM_CLEAR_PROGRESS_EN
  ,
  output logic [7:0]       progress
`endif
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_FIN} sdr_t;
  state_t            state, state_nx;
  sdr_t              sdr_st;
  logic              first;
  logic              enter;
  logic [SDR_AW-1:0] sdr_addr;
  logic [DDR_AW-1:0] ddr_addr;
  logic              ddr_we;
  // first marks the one cycle after reset release that may auto-start
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      first <= 1'b1;
    end else begin
      state <= state_nx;
      first <= 1'b0;
    end
  always_comb begin
    state_nx = state == SWEEP ? (sdr_done && ddr_done ? DONE : SWEEP)
             : (start || (state == IDLE && AUTO_START && first)) ? SWEEP : state;
    enter    = state != SWEEP && state_nx == SWEEP;
  end
  always_comb begin
    busy         = state == SWEEP;
    sdr_done     = sdr_st == S_FIN;
    mem.sdr_we   = sdr_st == S_WAIT;
    mem.sdr_addr = sdr_addr;
    mem.ddr_we   = ddr_we;
    mem.ddr_addr = ddr_addr;
  end
  // the terminal address holds rather than wrapping
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      sdr_st   <= S_ISSUE;
      sdr_addr <= '0;
    end else if (enter) begin
      sdr_st   <= S_ISSUE;
      sdr_addr <= '0;
    end else if (busy) begin
      if (sdr_st == S_ISSUE && !hold) sdr_st <= S_WAIT;
      else if (sdr_st == S_WAIT && mem.sdr_ack) begin
        sdr_st   <= &sdr_addr ? S_FIN : S_ISSUE;
        sdr_addr <= &sdr_addr ? sdr_addr : sdr_addr + 1'b1;
      end
    end
  // ddr_we/ddr_addr only move on an accept, so they stay frozen under waitrequest
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      ddr_we   <= 1'b0;
      ddr_addr <= '0;
      ddr_done <= 1'b0;
    end else if (enter) begin
      ddr_we   <= 1'b0;
      ddr_addr <= '0;
      ddr_done <= 1'b0;
    end else if (busy) begin
      if (ddr_we && !mem.ddr_busy) begin
        ddr_done <= &ddr_addr;
        ddr_we   <= !(&ddr_addr) && !hold;
        ddr_addr <= &ddr_addr ? ddr_addr : ddr_addr + 1'b1;
      end else if (!ddr_we && !ddr_done && !hold) ddr_we <= 1'b1;
    end
`ifdef MEM_CLEAR_PROGRESS_EN
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) progress <= 8'h00;
    else progress <= sdr_done ? 8'hFF : sdr_addr[SDR_AW-1 -: 8];
`endif
endmodule

// File: tb/tb_mem_clear_sched.sv
// tb_mem_clear_sched: scoreboard bench for mem_clear_sched (auto-start instance a, manual-start instance b)
module tb_mem_clear_sched;
`ifdef MEM_CLEAR_PROGRESS_EN
  localparam int SAW = 10;
`else
  localparam int SAW = 4;
`endif
  localparam int DAW = 3;
  logic clk_sys, reset_n, start, hold, sdr_done, ddr_done, busy;
  logic reset_nb, start_b, sdr_done_b, ddr_done_b, busy_b;
  int   n_chk, n_fail, ack_cnt;
  mem_clear_sched_if #(.SDR_AW(SAW), .DDR_AW(DAW)) m ();
  mem_clear_sched_if #(.SDR_AW(SAW), .DDR_AW(DAW)) mb ();
`ifdef MEM_CLEAR_PROGRESS_EN
  logic [7:0] progress, progress_b;
`endif
  mem_clear_sched #(.SDR_AW(SAW), .DDR_AW(DAW), .AUTO_START(1'b1)) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .hold(hold), .mem(m),
    .sdr_done(sdr_done), .ddr_done(ddr_done), .busy(busy)
`ifdef MEM_CLEAR_PROGRESS_EN
    , .progress(progress)
`endif
  );
  mem_clear_sched #(.SDR_AW(SAW), .DDR_AW(DAW), .AUTO_START(1'b0)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_nb), .start(start_b), .hold(1'b0), .mem(mb),
    .sdr_done(sdr_done_b), .ddr_done(ddr_done_b), .busy(busy_b)
`ifdef MEM_CLEAR_PROGRESS_EN
    , .progress(progress_b)
`endif
  );
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // advance one clock, sample point is 1 time unit after the edge; acks sdr_we two cycles after it rises
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (m.sdr_ack) m.sdr_ack = 1'b0;
    else if (m.sdr_we) begin
      ack_cnt++;
      if (ack_cnt >= 2) begin
        m.sdr_ack = 1'b1;
        ack_cnt = 0;
      end
    end
  endtask

  task automatic restart_a();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reset_nb = 1'b0; start = 1'b0; start_b = 1'b0; hold = 1'b0;
    m.sdr_ack = 1'b0; m.ddr_busy = 1'b0; mb.sdr_ack = 1'b0; mb.ddr_busy = 1'b0; ack_cnt = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    n_chk++;
    if ({busy, sdr_done, ddr_done, m.sdr_we, m.ddr_we, m.sdr_addr, m.ddr_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b sd=%b dd=%b swe=%b dwe=%b sa=%0h da=%0h want all 0",
               busy, sdr_done, ddr_done, m.sdr_we, m.ddr_we, m.sdr_addr, m.ddr_addr);
    end
`ifdef MEM_CLEAR_PROGRESS_EN
    n_chk++;
    if (progress !== 8'h00) begin n_fail++; $display("FAIL reset_progress: got %0h want 0", progress); end
`endif
    reset_n = 1'b1; reset_nb = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b1 || m.sdr_we !== 1'b0 || m.ddr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_start: got busy=%b swe=%b dwe=%b want busy=1 swe=0 dwe=0", busy, m.sdr_we, m.ddr_we);
    end
  endtask

  task automatic test_sweep();
    logic [SAW-1:0] sq[$];
    logic [DAW-1:0] dq[$];
    logic [SAW-1:0] se;
    logic [DAW-1:0] de;
    int   last_acc = -1;
    bit   prev_we = 1'b0, fin = 1'b0;
    for (int i = 0; i < (1 << SAW); i++) sq.push_back(SAW'(i));
    for (int i = 0; i < (1 << DAW); i++) dq.push_back(DAW'(i));
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (m.ddr_we && !m.ddr_busy) begin
        n_chk++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL ddr_extra: got write at %0d want none", m.ddr_addr);
        end else begin
          de = dq.pop_front();
          if (m.ddr_addr !== de) begin n_fail++; $display("FAIL ddr_addr: got %0d want %0d", m.ddr_addr, de); end
        end
        if (last_acc >= 0) begin
          n_chk++;
          if (c - last_acc != 1) begin n_fail++; $display("FAIL ddr_gap: got %0d cycles want 1", c - last_acc); end
        end
        last_acc = c;
      end
      if (m.sdr_we && !prev_we) begin
        n_chk++;
        if (sq.size() == 0) begin
          n_fail++;
          $display("FAIL sdr_extra: got write at %0d want none", m.sdr_addr);
        end else begin
          se = sq.pop_front();
          if (m.sdr_addr !== se) begin n_fail++; $display("FAIL sdr_addr: got %0d want %0d", m.sdr_addr, se); end
        end
      end
`ifdef MEM_CLEAR_PROGRESS_EN
      if (m.sdr_we && m.sdr_addr == SAW'(256)) begin
        n_chk++;
        if (progress !== 8'h40) begin n_fail++; $display("FAIL progress_mid: got %0h want 40", progress); end
      end
`endif
      prev_we = m.sdr_we;
      if (sdr_done && ddr_done) begin
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_on_done: got %b want 1", busy); end
        tick();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b want 0", busy); end
        fin = 1'b1;
      end else tick();
    end
    n_chk++;
    if (!fin || sq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_complete: got fin=%b sdr_left=%0d ddr_left=%0d want 1 0 0", fin, sq.size(), dq.size());
    end
`ifdef MEM_CLEAR_PROGRESS_EN
    n_chk++;
    if (progress !== 8'hFF) begin n_fail++; $display("FAIL progress_done: got %0h want ff", progress); end
`endif
  endtask

  task automatic test_restart_in_done();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (sdr_done !== 1'b1 || ddr_done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold: got sd=%b dd=%b busy=%b want 1 1 0", sdr_done, ddr_done, busy);
      end
    end
    restart_a();
    n_chk++;
    if (busy !== 1'b1 || sdr_done !== 1'b0 || ddr_done !== 1'b0 || m.sdr_addr !== '0 || m.ddr_addr !== '0) begin
      n_fail++;
      $display("FAIL restart_clear: got busy=%b sd=%b dd=%b sa=%0d da=%0d want 1 0 0 0 0",
               busy, sdr_done, ddr_done, m.sdr_addr, m.ddr_addr);
    end
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 20000) begin tick(); c++; end
    n_chk++;
    if (busy !== 1'b0 || sdr_done !== 1'b1 || ddr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: got busy=%b sd=%b dd=%b want 0 1 1", name, busy, sdr_done, ddr_done);
    end
  endtask

  task automatic test_ddr_stall();
    int c = 0;
    bit bad = 1'b0;
    restart_a();
    while (!(m.ddr_we && m.ddr_addr == DAW'(3)) && c < 100) begin tick(); c++; end
    n_chk++;
    if (!(m.ddr_we && m.ddr_addr == DAW'(3))) begin n_fail++; $display("FAIL stall_reach: got timeout want ddr_addr 3"); end
    m.ddr_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m.ddr_we !== 1'b1 || m.ddr_addr !== DAW'(3)) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL stall_stable: got we/addr moved want we=1 addr=3"); end
    m.ddr_busy = 1'b0;
    tick();
    n_chk++;
    if (m.ddr_we !== 1'b1 || m.ddr_addr !== DAW'(4)) begin
      n_fail++;
      $display("FAIL stall_resume: got we=%b addr=%0d want 1 4", m.ddr_we, m.ddr_addr);
    end
    wait_idle("stall");
  endtask

  task automatic test_start_ignored();
    int c = 0;
    restart_a();
    while (!(m.sdr_we && m.sdr_addr == SAW'(2)) && c < 200) begin tick(); c++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || m.sdr_addr !== SAW'(2)) begin
      n_fail++;
      $display("FAIL start_in_sweep: got busy=%b sa=%0d want 1 2", busy, m.sdr_addr);
    end
    c = 0;
    while (m.sdr_we && c < 50) begin tick(); c++; end
    while (!m.sdr_we && c < 100) begin tick(); c++; end
    n_chk++;
    if (m.sdr_we !== 1'b1 || m.sdr_addr !== SAW'(3)) begin
      n_fail++;
      $display("FAIL start_continue: got we=%b sa=%0d want 1 3", m.sdr_we, m.sdr_addr);
    end
    wait_idle("ignored");
  endtask

  task automatic test_hold();
    int c = 0;
    bit bad = 1'b0;
    restart_a();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m.sdr_we || m.ddr_we) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL hold_start: got a write request want none"); end
    hold = 1'b0;
    while (!(m.sdr_we && m.sdr_addr == SAW'(5)) && c < 500) begin tick(); c++; end
    hold = 1'b1;
    c = 0;
    while (m.sdr_we && c < 50) begin tick(); c++; end
    n_chk++;
    if (m.sdr_we !== 1'b0 || m.sdr_addr !== SAW'(6)) begin
      n_fail++;
      $display("FAIL hold_complete: got we=%b sa=%0d want 0 6", m.sdr_we, m.sdr_addr);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m.sdr_we || m.ddr_we) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL hold_block: got a write request want none"); end
    hold = 1'b0;
    c = 0;
    while (!m.sdr_we && c < 20) begin tick(); c++; end
    n_chk++;
    if (m.sdr_we !== 1'b1 || m.sdr_addr !== SAW'(6)) begin
      n_fail++;
      $display("FAIL hold_resume: got we=%b sa=%0d want 1 6", m.sdr_we, m.sdr_addr);
    end
    wait_idle("hold");
  endtask

  task automatic test_async_reset();
    n_chk++;
    if (busy_b !== 1'b0 || mb.sdr_we !== 1'b0 || mb.ddr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b_idle: got busy=%b swe=%b dwe=%b want 0 0 0", busy_b, mb.sdr_we, mb.ddr_we);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (12) tick();
    n_chk++;
    if (mb.sdr_we !== 1'b1 || ddr_done_b !== 1'b1 || mb.ddr_addr !== DAW'(7)) begin
      n_fail++;
      $display("FAIL b_pending: got swe=%b dd=%b da=%0d want 1 1 7", mb.sdr_we, ddr_done_b, mb.ddr_addr);
    end
    #3;
    reset_nb = 1'b0;
    #1;
    n_chk++;
    if ({busy_b, sdr_done_b, ddr_done_b, mb.sdr_we, mb.ddr_we, mb.sdr_addr, mb.ddr_addr} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b sd=%b dd=%b swe=%b dwe=%b da=%0d want all 0",
               busy_b, sdr_done_b, ddr_done_b, mb.sdr_we, mb.ddr_we, mb.ddr_addr);
    end
    reset_nb = 1'b1;
    repeat (5) tick();
    n_chk++;
    if (busy_b !== 1'b0 || mb.sdr_we !== 1'b0 || mb.ddr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b_stay_idle: got busy=%b swe=%b dwe=%b want 0 0 0", busy_b, mb.sdr_we, mb.ddr_we);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_chk++;
    if (busy_b !== 1'b1) begin n_fail++; $display("FAIL b_start: got busy=%b want 1", busy_b); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_sweep();
    test_restart_in_done();
    test_sweep();
    test_ddr_stall();
    test_start_ignored();
    test_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
